// File: rtl/imem_loader.sv
// imem_loader
//
// Loads a length-prefixed program image from a byte stream (typically UART RX)
// into instruction memory through a single-cycle word write port.
//
// Stream format:
//   N[7:0] N[15:8] N[23:16] N[31:24]   word count, little-endian
//   4*N data bytes                     little-endian words
//   1 checksum byte                    8-bit sum of all data bytes
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   start     one-cycle pulse, arms the loader (ignored while busy)
//   rx_data   incoming byte
//   rx_valid  rx_data valid
//   rx_ready  loader accepts a byte this cycle
//   wr_en     one-cycle IMEM write strobe
//   wr_addr   IMEM byte address (word-aligned)
//   wr_data   IMEM write word
//   busy      image transfer in progress
//   done      image loaded, checksum ok (level)
//   err       length or checksum error (level)

module imem_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int          WCW   = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [1:0]       byte_cnt;
  logic [WCW-1:0]   word_cnt;
  logic [31:0]      len;
  logic [23:0]      shift;
  logic [7:0]       csum;

  logic             accept;
  logic             last_byte;
  logic             last_word;
  logic             len_bad;
  logic             arm;
  logic [31:0]      word;
  logic [31:0]      word_idx;

  // rx_ready is a pure decode of the state register, so it never stalls
  // inside LEN/DATA/CSUM.
  assign rx_ready  = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign busy      = rx_ready;
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERR);

  assign accept    = rx_valid && rx_ready;
  assign last_byte = (byte_cnt == 2'd3);

  // The first three bytes of a word sit in shift as {b2,b1,b0}; the fourth
  // byte completes the word straight from the input.
  assign word      = {rx_data, shift};
  assign word_idx  = 32'(word_cnt);
  assign last_word = (word_idx == len - 32'd1);
  assign len_bad   = (word == 32'd0) || (word > MAX_N);

  // start only has an effect while not busy.
  assign arm       = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (arm) begin
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        if (accept && last_byte) begin
          state_nxt = len_bad ? S_ERR : S_DATA;
        end
      end
      S_DATA: begin
        if (accept && last_byte && last_word) begin
          state_nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Byte assembly, checksum and the IMEM write port. wr_addr/wr_data only
  // change when a word completes, so they hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      word_cnt <= '0;
      len      <= 32'd0;
      shift    <= 24'd0;
      csum     <= 8'd0;
      wr_en    <= 1'b0;
      wr_addr  <= 32'd0;
      wr_data  <= 32'd0;
    end else begin
      wr_en <= 1'b0;
      if (arm) begin
        byte_cnt <= 2'd0;
        word_cnt <= '0;
        len      <= 32'd0;
        shift    <= 24'd0;
        csum     <= 8'd0;
      end else if (accept) begin
        case (state)
          S_LEN: begin
            shift    <= {rx_data, shift[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              len <= word;
            end
          end
          S_DATA: begin
            shift    <= {rx_data, shift[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
            csum     <= csum + rx_data;
            if (last_byte) begin
              wr_en    <= 1'b1;
              wr_addr  <= ADDR_BASE + (word_idx << 2);
              wr_data  <= word;
              word_cnt <= word_cnt + WCW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//
// Directed bench for imem_loader. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle from the active edge.
// A monitor logs every write strobe so each test can check count, address
// and data against hand-computed values.

module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(
    .ADDR_BASE (BASE),
    .MAX_WORDS (8192)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          wr_count = 0;
  int          ready_drops = 0;
  int          base = 0;
  logic [31:0] addr_log [64];
  logic [31:0] data_log [64];
  logic [7:0]  stream [$];

  always @(negedge clk) begin
    if (wr_en) begin
      addr_log[wr_count % 64] = wr_addr;
      data_log[wr_count % 64] = wr_data;
      wr_count++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte for one cycle; called and returns at a falling edge.
  task automatic applyStimulus(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    if (!rx_ready) ready_drops++;
    @(negedge clk);
  endtask

  task automatic sendStream();
    foreach (stream[i]) applyStimulus(stream[i]);
    stream.delete();
    rx_valid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    @(negedge clk);
    checkOutput("rst_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("rst_wr_en",    32'(wr_en),    32'd0);
    checkOutput("rst_wr_addr",  wr_addr,       32'd0);
    checkOutput("rst_wr_data",  wr_data,       32'd0);
    checkOutput("rst_busy",     32'(busy),     32'd0);
    checkOutput("rst_done",     32'(done),     32'd0);
    checkOutput("rst_err",      32'(err),      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Bytes offered in IDLE are refused
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    waitCycles(3);
    checkOutput("idle_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("idle_busy",     32'(busy),     32'd0);

    // start together with a byte in IDLE: byte AA must not enter the length
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base = wr_count;
    ready_drops = 0;
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
    sendStream();
    waitCycles(1);
    checkOutput("t1_writes",  32'(wr_count - base), 32'd1);
    checkOutput("t1_addr",    addr_log[base % 64],  BASE);
    checkOutput("t1_data",    data_log[base % 64],  32'h1234_5678);
    checkOutput("t1_done",    32'(done),  32'd1);
    checkOutput("t1_err",     32'(err),   32'd0);
    checkOutput("t1_busy",    32'(busy),  32'd0);
    checkOutput("t1_drops",   32'(ready_drops), 32'd0);
    waitCycles(3);
    checkOutput("t1_done_hold",   32'(done), 32'd1);
    checkOutput("t1_writes_hold", 32'(wr_count - base), 32'd1);
    checkOutput("t1_addr_hold",   wr_addr, BASE);

    // Two words, one byte per cycle
    pulseStart();
    checkOutput("t2_armed_busy", 32'(busy), 32'd1);
    checkOutput("t2_armed_done", 32'(done), 32'd0);
    base = wr_count;
    ready_drops = 0;
    stream = '{8'h02, 8'h00, 8'h00, 8'h00,
               8'h01, 8'h02, 8'h03, 8'h04,
               8'hD0, 8'hC0, 8'hB0, 8'hA0, 8'hEA};
    sendStream();
    waitCycles(1);
    checkOutput("t2_writes", 32'(wr_count - base), 32'd2);
    checkOutput("t2_addr0",  addr_log[base % 64],       BASE);
    checkOutput("t2_data0",  data_log[base % 64],       32'h0403_0201);
    checkOutput("t2_addr1",  addr_log[(base + 1) % 64], BASE + 32'd4);
    checkOutput("t2_data1",  data_log[(base + 1) % 64], 32'hA0B0_C0D0);
    checkOutput("t2_done",   32'(done), 32'd1);
    checkOutput("t2_drops",  32'(ready_drops), 32'd0);

    // Bad checksum
    pulseStart();
    base = wr_count;
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h15};
    sendStream();
    waitCycles(1);
    checkOutput("t3_err",    32'(err),  32'd1);
    checkOutput("t3_done",   32'(done), 32'd0);
    checkOutput("t3_writes", 32'(wr_count - base), 32'd1);
    checkOutput("t3_data",   data_log[base % 64], 32'h1234_5678);

    // Zero length
    pulseStart();
    base = wr_count;
    stream = '{8'h00, 8'h00, 8'h00, 8'h00};
    sendStream();
    checkOutput("t4a_err",      32'(err),      32'd1);
    checkOutput("t4a_busy",     32'(busy),     32'd0);
    checkOutput("t4a_rx_ready", 32'(rx_ready), 32'd0);
    waitCycles(2);
    checkOutput("t4a_writes", 32'(wr_count - base), 32'd0);

    // Length MAX_WORDS+1
    pulseStart();
    base = wr_count;
    stream = '{8'h01, 8'h20, 8'h00, 8'h00};
    sendStream();
    checkOutput("t4b_err",  32'(err),  32'd1);
    checkOutput("t4b_done", 32'(done), 32'd0);
    waitCycles(2);
    checkOutput("t4b_writes", 32'(wr_count - base), 32'd0);

    // Length exactly MAX_WORDS is accepted, then reset after 2 data bytes
    pulseStart();
    stream = '{8'h00, 8'h20, 8'h00, 8'h00};
    sendStream();
    checkOutput("t4c_busy", 32'(busy), 32'd1);
    checkOutput("t4c_err",  32'(err),  32'd0);
    applyStimulus(8'h78);
    applyStimulus(8'h56);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_busy",     32'(busy),     32'd0);
    checkOutput("t5_wr_en",    32'(wr_en),    32'd0);
    checkOutput("t5_rx_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    pulseStart();
    base = wr_count;
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
    sendStream();
    waitCycles(1);
    checkOutput("t5_writes", 32'(wr_count - base), 32'd1);
    checkOutput("t5_addr",   addr_log[base % 64], BASE);
    checkOutput("t5_data",   data_log[base % 64], 32'h1234_5678);
    checkOutput("t5_done",   32'(done), 32'd1);

    // Reset while the write strobe is high drops it immediately
    pulseStart();
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    sendStream();
    checkOutput("t5b_wr_en_pre", 32'(wr_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5b_wr_en",   32'(wr_en),   32'd0);
    checkOutput("t5b_wr_data", wr_data,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // start while busy is ignored
    pulseStart();
    base = wr_count;
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56};
    sendStream();
    start = 1'b1;
    applyStimulus(8'h34);
    start = 1'b0;
    applyStimulus(8'h12);
    applyStimulus(8'h14);
    rx_valid = 1'b0;
    waitCycles(1);
    checkOutput("t6_writes", 32'(wr_count - base), 32'd1);
    checkOutput("t6_data",   data_log[base % 64], 32'h1234_5678);
    checkOutput("t6_done",   32'(done), 32'd1);
    checkOutput("t6_err",    32'(err),  32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
